alu_exec: RTL and testbench

Multi-cycle execute unit for the RV32 core that consumes the 4-bit `alu_control` code produced by the ALU decoder and computes the result. Sits in the EX stage between the decoder/register-read and the write-back/memory logic. It uses a valid/ready handshake on both sides. Logic ops, arithmetic ops and set-less-than complete in one cycle. Shifts run iteratively, one bit per cycle.

---
 rtl/alu_pkg.sv | 23 ++
 rtl/alu_core.sv | 26 ++
 rtl/alu_exec.sv | 117 +++++++++++
 tb/tb_alu_exec.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - ALU operation codes, execute FSM state type and decode helper
package alu_pkg;

   localparam logic [3:0] ALU_AND = 4'b0000;
   localparam logic [3:0] ALU_OR  = 4'b0001;
   localparam logic [3:0] ALU_ADD = 4'b0010;
   localparam logic [3:0] ALU_SUB = 4'b0110;
   localparam logic [3:0] ALU_SLT = 4'b0111;
   localparam logic [3:0] ALU_SLL = 4'b1000;
   localparam logic [3:0] ALU_SRL = 4'b1001;
   localparam logic [3:0] ALU_SRA = 4'b1010;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } alu_state_t;

   function automatic logic is_shift(input logic [3:0] code);
      return (code == ALU_SLL) || (code == ALU_SRL) || (code == ALU_SRA);
   endfunction

endpackage

// File: rtl/alu_core.sv
// rtl/alu_core.sv - combinational AND/OR/ADD/SUB/SLT datapath
// Shift codes and unknown codes yield zero; shifts are iterated in alu_exec.
module alu_core
   import alu_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [3:0]      alu_control,
   input  logic [XLEN-1:0] op_a,
   input  logic [XLEN-1:0] op_b,
   output logic [XLEN-1:0] y
);

   always_comb begin
      y = '0;
      case (alu_control)
         ALU_AND: y = op_a & op_b;
         ALU_OR:  y = op_a | op_b;
         ALU_ADD: y = op_a + op_b;
         ALU_SUB: y = op_a - op_b;
         ALU_SLT: y = {{(XLEN-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
         default: y = '0;
      endcase
   end

endmodule

// File: rtl/alu_exec.sv
// rtl/alu_exec.sv - multi-cycle EX-stage ALU with valid/ready on both sides
// Single-cycle ops finish on accept; shifts step one bit per cycle.
module alu_exec
   import alu_pkg::*;
#(
   parameter int XLEN = 32,
   parameter int SHW  = $clog2(XLEN)
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [3:0]      alu_control,
   input  logic [XLEN-1:0] op_a,
   input  logic [XLEN-1:0] op_b,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] result,
   output logic            zero
);

   alu_state_t      state, state_nxt;
   logic [3:0]      op_q;
   logic [SHW-1:0]  cnt_q, cnt_nxt;
   logic [SHW-1:0]  shamt;
   logic [XLEN-1:0] result_nxt;
   logic [XLEN-1:0] core_y;
   logic            accept;

   function automatic logic [XLEN-1:0] shift_one(input logic [3:0] code,
                                                 input logic [XLEN-1:0] v);
      case (code)
         ALU_SLL: return {v[XLEN-2:0], 1'b0};
         ALU_SRL: return {1'b0, v[XLEN-1:1]};
         ALU_SRA: return {v[XLEN-1], v[XLEN-1:1]};
         default: return v;
      endcase
   endfunction

   alu_core #(.XLEN(XLEN)) u_core (
      .alu_control (alu_control),
      .op_a        (op_a),
      .op_b        (op_b),
      .y           (core_y)
   );

   assign shamt  = op_b[SHW-1:0];
   assign accept = in_valid && (state == IDLE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // The first shift step happens on the accepting edge, so a shift by n
   // spends n-1 cycles in SHIFT and a shift by 1 finishes like an ADD.
   always_comb begin
      state_nxt = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      case (state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               if (is_shift(alu_control) && (shamt > SHW'(1))) state_nxt = SHIFT;
               else                                            state_nxt = DONE;
            end
         end
         SHIFT: begin
            if (cnt_q == SHW'(1)) state_nxt = DONE;
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // result doubles as the shift working register; it is only exposed in DONE.
   always_comb begin
      result_nxt = result;
      cnt_nxt    = cnt_q;
      if (accept) begin
         if (is_shift(alu_control)) begin
            if (shamt == '0) begin
               result_nxt = op_a;
               cnt_nxt    = '0;
            end else begin
               result_nxt = shift_one(alu_control, op_a);
               cnt_nxt    = shamt - SHW'(1);
            end
         end else begin
            result_nxt = core_y;
            cnt_nxt    = '0;
         end
      end else if (state == SHIFT) begin
         result_nxt = shift_one(op_q, result);
         cnt_nxt    = cnt_q - SHW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_q   <= ALU_AND;
         cnt_q  <= '0;
         result <= '0;
         zero   <= 1'b1;
      end else begin
         if (accept) op_q <= alu_control;
         cnt_q  <= cnt_nxt;
         result <= result_nxt;
         zero   <= (result_nxt == '0);
      end
   end

endmodule

// File: tb/tb_alu_exec.sv
// tb/tb_alu_exec.sv - scoreboard bench for alu_exec
module tb_alu_exec;
   import alu_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [3:0]  alu_control;
   logic [31:0] op_a;
   logic [31:0] op_b;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] result;
   logic        zero;

   alu_exec #(.XLEN(32)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .alu_control (alu_control),
      .op_a        (op_a),
      .op_b        (op_b),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .result      (result),
      .zero        (zero)
   );

   always #5 clk = ~clk;

   typedef struct {
      string       tag;
      logic [31:0] res;
      int          lat;
      int          acc;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   failures = 0;
   int   cyc = 0;

   always @(posedge clk) cyc++;

   task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] model(logic [3:0] c, logic [31:0] a, logic [31:0] b);
      case (c)
         ALU_AND: return a & b;
         ALU_OR:  return a | b;
         ALU_ADD: return a + b;
         ALU_SUB: return a - b;
         ALU_SLT: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         ALU_SLL: return a << b[4:0];
         ALU_SRL: return a >> b[4:0];
         ALU_SRA: return 32'($signed(a) >>> b[4:0]);
         default: return 32'd0;
      endcase
   endfunction

   // Output monitor: pops the scoreboard on each handshake, checks hold stability.
   logic [31:0] held_res;
   logic        held_zero;
   logic        held_pend = 1'b0;
   int          first_cyc = 0;
   exp_t        mon_e;

   always @(negedge clk) begin
      if (!rst_n) begin
         held_pend = 1'b0;
      end else begin
         if (held_pend) begin
            check("hold_valid", out_valid, 1);
            check("hold_result", result, held_res);
            check("hold_zero", zero, held_zero);
         end
         if (out_valid && !held_pend) first_cyc = cyc;
         if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
               check("spurious_out", sb.size(), 1);
            end else begin
               mon_e = sb.pop_front();
               check({mon_e.tag, "_result"}, result, mon_e.res);
               check({mon_e.tag, "_zero"}, zero, (mon_e.res == 32'd0));
               check({mon_e.tag, "_latency"}, first_cyc - mon_e.acc, mon_e.lat);
            end
         end
         held_pend = out_valid && !out_ready;
         held_res  = result;
         held_zero = zero;
      end
   end

   task automatic send(string tag, logic [3:0] code, logic [31:0] a, logic [31:0] b,
                       logic [31:0] res, int lat);
      int   n = 0;
      exp_t e;
      @(posedge clk); #1;
      in_valid = 1'b1; alu_control = code; op_a = a; op_b = b;
      @(negedge clk);
      while (!in_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) begin
         check({tag, "_accept"}, in_ready, 1);
      end else begin
         e.tag = tag; e.res = res; e.lat = lat; e.acc = cyc;
         sb.push_back(e);
      end
      @(posedge clk); #1;
      in_valid = 1'b0; alu_control = 4'($urandom); op_a = $urandom; op_b = $urandom;
   endtask

   task automatic drain(string tag);
      int n = 0;
      while (sb.size() != 0 && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (sb.size() != 0) begin
         check({tag, "_timeout"}, sb.size(), 0);
         sb.delete();
      end
      @(negedge clk);
      check({tag, "_in_ready"}, in_ready, 1);
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   logic [3:0] codes [9] = '{ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_SLT,
                             ALU_SLL, ALU_SRL, ALU_SRA, 4'b0011};

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      alu_control = 4'd0; op_a = 32'd0; op_b = 32'd0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_in_ready", in_ready, 1);
      check("rst_out_valid", out_valid, 0);
      check("rst_result", result, 0);
      check("rst_zero", zero, 1);
      @(negedge clk); rst_n = 1'b1;

      send("add", ALU_ADD, 32'd5, 32'd7, 32'd12, 1);               drain("add");
      send("sub_eq", ALU_SUB, 32'd3, 32'd3, 32'd0, 1);             drain("sub_eq");
      send("sub_wrap", ALU_SUB, 32'd0, 32'd1, 32'hFFFF_FFFF, 1);   drain("sub_wrap");
      send("slt_neg", ALU_SLT, 32'hFFFF_FFFF, 32'd1, 32'd1, 1);    drain("slt_neg");
      send("slt_swap", ALU_SLT, 32'd1, 32'hFFFF_FFFF, 32'd0, 1);   drain("slt_swap");
      send("and", ALU_AND, 32'hF0F0_1234, 32'h0FF0_FF00, 32'h00F0_1200, 1); drain("and");
      send("or", ALU_OR, 32'hF000_0001, 32'h0000_0F10, 32'hF000_0F11, 1);   drain("or");
      send("bad_code", 4'b1111, 32'h1234_5678, 32'h1, 32'd0, 1);   drain("bad_code");
      send("sra4", ALU_SRA, 32'h8000_0000, 32'd4, 32'hF800_0000, 4);  drain("sra4");
      send("srl4", ALU_SRL, 32'h8000_0000, 32'd4, 32'h0800_0000, 4);  drain("srl4");
      send("sll0", ALU_SLL, 32'd1, 32'd0, 32'd1, 1);               drain("sll0");
      send("sll1", ALU_SLL, 32'h4000_0001, 32'd1, 32'h8000_0002, 1); drain("sll1");
      send("sll31_hi", ALU_SLL, 32'd3, 32'hFFFF_FFFF, 32'h8000_0000, 31); drain("sll31_hi");

      // Backpressure: result must hold, in_ready stays low, new requests ignored.
      out_ready = 1'b0;
      send("bp_sub", ALU_SUB, 32'd10, 32'd3, 32'd7, 1);
      begin
         int n = 0;
         while (!out_valid && n < 50) begin
            @(negedge clk);
            n++;
         end
         check("bp_valid_seen", out_valid, 1);
      end
      repeat (3) begin
         check("bp_in_ready", in_ready, 0);
         @(posedge clk); #1;
         in_valid = 1'b1; alu_control = ALU_ADD; op_a = $urandom; op_b = $urandom;
         @(negedge clk);
      end
      @(posedge clk); #1;
      in_valid = 1'b0; out_ready = 1'b1;
      drain("bp");
      repeat (4) begin
         @(negedge clk);
         check("bp_no_extra", out_valid, 0);
      end

      // Reset during a long shift discards the operation.
      @(posedge clk); #1;
      in_valid = 1'b1; alu_control = ALU_SLL; op_a = 32'd1; op_b = 32'd31;
      @(negedge clk);
      check("rstmid_accept", in_ready, 1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (9) @(posedge clk);
      #1;
      check("rstmid_busy", in_ready, 0);
      #1;
      rst_n = 1'b0;
      #1;
      check("rstmid_out_valid", out_valid, 0);
      check("rstmid_result", result, 0);
      check("rstmid_zero", zero, 1);
      check("rstmid_in_ready", in_ready, 1);
      @(negedge clk); rst_n = 1'b1;
      repeat (40) @(negedge clk);
      check("rstmid_no_output", out_valid, 0);
      send("add_after_rst", ALU_ADD, 32'h7FFF_FFFF, 32'd1, 32'h8000_0000, 1);
      drain("add_after_rst");

      for (int i = 0; i < 16; i++) begin
         logic [3:0]  c;
         logic [31:0] a, b;
         int          lat;
         c = codes[$urandom_range(0, 8)];
         a = $urandom;
         b = (i % 4 == 0) ? a : $urandom;
         lat = (is_shift(c) && b[4:0] != 5'd0) ? int'(b[4:0]) : 1;
         send($sformatf("rnd%0d", i), c, a, b, model(c, a, b), lat);
         drain($sformatf("rnd%0d", i));
      end

      repeat (3) @(posedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
